mem_access_seq: RTL and testbench

Parametrised load/store sequencer for the cRISCV core: stalls the pipeline, issues one-cycle request strobes to one of `N_TGT` memory targets (cache, IO controllers, …) and selects the writeback source once that target signals ready. It replaces the single cache/IO handshake in the controller. New behaviour:

- per-target request and ready vectors;
- misaligned-access detection;
- a wait timeout with an error report to trap logic.

---
 rtl/mem_access_seq_if.sv | 30 +++
 rtl/mem_access_seq.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_seq_if.sv
// Load/store sequencer bus: instruction fields and per-target ready in,
// stall, strobes, writeback select, size/sign and fault report out.
interface mem_access_seq_if #(
  parameter int N_TGT = 2,
  parameter int TW    = 1
);
  logic [6:0]       OPCODE;
  logic [2:0]       FUNCT3;
  logic [1:0]       ADDR;
  logic [TW-1:0]    TGT;
  logic [N_TGT-1:0] RDY;
  logic             HOLD;
  logic [N_TGT-1:0] RREQ;
  logic [N_TGT-1:0] CWE;
  logic [TW:0]      CMUXSEL;
  logic [2:0]       LIM;
  logic             SIGNED;
  logic             ERR;
  logic [1:0]       ERR_CODE;

  modport master (
    input  OPCODE, FUNCT3, ADDR, TGT, RDY,
    output HOLD, RREQ, CWE, CMUXSEL, LIM, SIGNED, ERR, ERR_CODE
  );

  modport slave (
    output OPCODE, FUNCT3, ADDR, TGT, RDY,
    input  HOLD, RREQ, CWE, CMUXSEL, LIM, SIGNED, ERR, ERR_CODE
  );
endinterface

// File: rtl/mem_access_seq.sv
// Load/store sequencer: stalls the pipeline, strobes one of N_TGT memory targets,
// waits for that target's ready (with optional timeout) and selects writeback.
module mem_access_seq #(
  parameter int N_TGT   = 2,
  parameter int TW      = 1,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  mem_access_seq_if.master bus
);

  localparam logic [6:0]  OP_LOAD     = 7'b0000011;
  localparam logic [6:0]  OP_STORE    = 7'b0100011;
  localparam logic [1:0]  EC_MISALIGN = 2'd1;
  localparam logic [1:0]  EC_TIMEOUT  = 2'd2;
  localparam logic [TW:0] N_TGT_W     = (TW+1)'(N_TGT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             hold_q, hold_d;
  logic [N_TGT-1:0] rreq_q, rreq_d;
  logic [N_TGT-1:0] cwe_q, cwe_d;
  logic [TW:0]      cmuxsel_q, cmuxsel_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [TW-1:0]    tgt_q, tgt_d;
  logic             is_load_q, is_load_d;

  logic             is_ld, is_st, is_mem;
  logic             misaligned, tgt_bad;
  logic [N_TGT-1:0] tgt_onehot;
  logic             rdy_sel;
  logic             timeout_hit;
  logic             cnt_max;

  // Instruction decode on the live (unlatched) fields.
  always_comb begin
    is_ld      = (bus.OPCODE == OP_LOAD);
    is_st      = (bus.OPCODE == OP_STORE);
    is_mem     = is_ld | is_st;
    misaligned = ((bus.FUNCT3[1:0] == 2'b01) && bus.ADDR[0]) ||
                 ((bus.FUNCT3[1:0] == 2'b10) && (bus.ADDR != 2'b00));
    tgt_bad    = ({1'b0, bus.TGT} >= N_TGT_W);
  end

  always_comb begin
    tgt_onehot = '0;
    rdy_sel    = 1'b0;
    for (int t = 0; t < N_TGT; t++) begin
      if (bus.TGT == TW'(t)) tgt_onehot[t] = 1'b1;
      if (tgt_q == TW'(t))   rdy_sel       = bus.RDY[t];
    end
  end

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    cnt_max     = &cnt_q;
  end

  // State and output registers, updated on the falling edge like the controller.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      hold_q     <= 1'b0;
      rreq_q     <= '0;
      cwe_q      <= '0;
      cmuxsel_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      cnt_q      <= '0;
      funct3_q   <= 3'd0;
      tgt_q      <= '0;
      is_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rreq_q     <= rreq_d;
      cwe_q      <= cwe_d;
      cmuxsel_q  <= cmuxsel_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
      tgt_q      <= tgt_d;
      is_load_q  <= is_load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem) state_d = (misaligned || tgt_bad) ? S_FAULT : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Ready is checked before the timeout so a coincident ready wins.
        if (rdy_sel)          state_d = S_IDLE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_d     = hold_q;
    rreq_d     = '0;
    cwe_d      = '0;
    cmuxsel_d  = cmuxsel_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    funct3_d   = funct3_q;
    tgt_d      = tgt_q;
    is_load_d  = is_load_q;
    case (state_q)
      S_IDLE: begin
        hold_d    = 1'b0;
        cmuxsel_d = '0;
        if (is_mem) begin
          hold_d = 1'b1;
          if (misaligned) begin
            err_d      = 1'b1;
            err_code_d = EC_MISALIGN;
          end else if (tgt_bad) begin
            err_d      = 1'b1;
            err_code_d = EC_TIMEOUT;
          end else begin
            rreq_d    = is_ld ? tgt_onehot : '0;
            cwe_d     = is_st ? tgt_onehot : '0;
            funct3_d  = bus.FUNCT3;
            tgt_d     = bus.TGT;
            is_load_d = is_ld;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        if (rdy_sel) begin
          hold_d    = 1'b0;
          cmuxsel_d = is_load_q ? ({1'b0, tgt_q} + (TW+1)'(1)) : '0;
        end else if (timeout_hit) begin
          err_d      = 1'b1;
          err_code_d = EC_TIMEOUT;
        end else if (!cnt_max) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FAULT: begin
        hold_d = 1'b0;
      end
      default: begin
        hold_d = 1'b0;
      end
    endcase
  end

  assign bus.HOLD     = hold_q;
  assign bus.RREQ     = rreq_q;
  assign bus.CWE      = cwe_q;
  assign bus.CMUXSEL  = cmuxsel_q;
  assign bus.ERR      = err_q;
  assign bus.ERR_CODE = err_code_q;

  // Size and sign follow the latched access, not the live instruction.
  assign bus.LIM    = (funct3_q[1:0] == 2'b00) ? 3'd0 :
                      (funct3_q[1:0] == 2'b01) ? 3'd1 : 3'd3;
  assign bus.SIGNED = is_load_q && (funct3_q != 3'b100) && (funct3_q != 3'b101);

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: loads, stores, misalignment, timeout,
// back-to-back issue and asynchronous reset mid-wait.
module tb_mem_access_seq;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  logic clk = 1'b1;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   hc;

  always #5 clk = ~clk;

  mem_access_seq_if #(.N_TGT(2), .TW(1)) bus ();

  mem_access_seq #(.N_TGT(2), .TW(1), .TIMEOUT(4), .CW(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] a,
                        input logic t, input logic [1:0] r);
    bus.OPCODE = op;
    bus.FUNCT3 = f3;
    bus.ADDR   = a;
    bus.TGT    = t;
    bus.RDY    = r;
  endtask

  initial begin
    set_in(7'd0, 3'd0, 2'd0, 1'b0, 2'b00);
    #1 rst = 1'b1;
    #3;
    chk("rst_hold", bus.HOLD, 0);
    chk("rst_rreq", bus.RREQ, 0);
    chk("rst_cwe", bus.CWE, 0);
    chk("rst_cmux", bus.CMUXSEL, 0);
    chk("rst_err", bus.ERR, 0);
    chk("rst_code", bus.ERR_CODE, 0);
    #3 rst = 1'b0;
    tick();
    chk("idle_hold", bus.HOLD, 0);

    // LW to target 0, ready on third WAIT edge
    set_in(LOAD, 3'b010, 2'b00, 1'b0, 2'b00);
    tick();
    chk("lw_rreq", bus.RREQ, 2'b01);
    chk("lw_cwe", bus.CWE, 0);
    chk("lw_err", bus.ERR, 0);
    hc = int'(bus.HOLD);
    bus.OPCODE = 7'd0;
    tick();
    chk("lw_rreq_1cyc", bus.RREQ, 0);
    chk("lw_lim", bus.LIM, 3);
    chk("lw_signed", bus.SIGNED, 1);
    hc += int'(bus.HOLD);
    tick();
    hc += int'(bus.HOLD);
    tick();
    hc += int'(bus.HOLD);
    bus.RDY = 2'b01;
    tick();
    hc += int'(bus.HOLD);
    chk("lw_release", bus.HOLD, 0);
    chk("lw_cmux", bus.CMUXSEL, 1);
    chk("lw_hold_cycles", hc, 4);
    bus.RDY = 2'b00;
    tick();
    chk("lw_cmux_clear", bus.CMUXSEL, 0);

    // SB to target 1, ready from target 0 ignored
    set_in(STORE, 3'b000, 2'b11, 1'b1, 2'b01);
    tick();
    chk("sb_cwe", bus.CWE, 2'b10);
    chk("sb_rreq", bus.RREQ, 0);
    chk("sb_hold", bus.HOLD, 1);
    bus.OPCODE = 7'd0;
    tick();
    chk("sb_cwe_1cyc", bus.CWE, 0);
    chk("sb_signed", bus.SIGNED, 0);
    chk("sb_lim", bus.LIM, 0);
    tick();
    chk("sb_rdy0_ign_a", bus.HOLD, 1);
    tick();
    chk("sb_rdy0_ign_b", bus.HOLD, 1);
    bus.RDY = 2'b10;
    tick();
    chk("sb_release", bus.HOLD, 0);
    chk("sb_cmux", bus.CMUXSEL, 0);
    bus.RDY = 2'b00;
    tick();

    // LH misaligned
    set_in(LOAD, 3'b001, 2'b01, 1'b0, 2'b00);
    tick();
    chk("lh_mis_err", bus.ERR, 1);
    chk("lh_mis_code", bus.ERR_CODE, 1);
    chk("lh_mis_rreq", bus.RREQ, 0);
    chk("lh_mis_hold", bus.HOLD, 1);
    bus.OPCODE = 7'd0;
    tick();
    chk("lh_mis_err_1cyc", bus.ERR, 0);
    chk("lh_mis_hold_drop", bus.HOLD, 0);
    tick();
    chk("lh_mis_code_keep", bus.ERR_CODE, 1);

    // SW misaligned
    set_in(STORE, 3'b010, 2'b10, 1'b1, 2'b00);
    tick();
    chk("sw_mis_err", bus.ERR, 1);
    chk("sw_mis_cwe", bus.CWE, 0);
    bus.OPCODE = 7'd0;
    tick();

    // LBU with no ready: timeout on 4th WAIT edge
    set_in(LOAD, 3'b100, 2'b11, 1'b0, 2'b00);
    tick();
    chk("lbu_rreq", bus.RREQ, 2'b01);
    bus.OPCODE = 7'd0;
    tick();
    chk("lbu_signed", bus.SIGNED, 0);
    chk("lbu_lim", bus.LIM, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("lbu_wait%0d_err", i), bus.ERR, 0);
      chk($sformatf("lbu_wait%0d_hold", i), bus.HOLD, 1);
    end
    tick();
    chk("to_err", bus.ERR, 1);
    chk("to_code", bus.ERR_CODE, 2);
    chk("to_hold", bus.HOLD, 1);
    tick();
    chk("to_hold_drop", bus.HOLD, 0);
    chk("to_err_1cyc", bus.ERR, 0);
    chk("to_code_keep", bus.ERR_CODE, 2);

    // LBU again, ready arrives on the 4th WAIT edge: ready wins
    set_in(LOAD, 3'b100, 2'b00, 1'b0, 2'b00);
    tick();
    bus.OPCODE = 7'd0;
    tick();
    tick();
    tick();
    tick();
    bus.RDY = 2'b01;
    tick();
    chk("race_err", bus.ERR, 0);
    chk("race_hold", bus.HOLD, 0);
    chk("race_cmux", bus.CMUXSEL, 1);
    bus.RDY = 2'b00;
    tick();
    chk("race_no_late_err", bus.ERR, 0);

    // Back-to-back loads, minimum latency
    set_in(LOAD, 3'b010, 2'b00, 1'b1, 2'b00);
    tick();
    chk("b2b1_rreq", bus.RREQ, 2'b10);
    chk("b2b1_hold_k", bus.HOLD, 1);
    bus.OPCODE = 7'd0;
    tick();
    chk("b2b1_hold_k1", bus.HOLD, 1);
    bus.RDY = 2'b10;
    tick();
    chk("b2b1_release", bus.HOLD, 0);
    chk("b2b1_cmux", bus.CMUXSEL, 2);
    set_in(LOAD, 3'b010, 2'b00, 1'b0, 2'b00);
    tick();
    chk("b2b2_rreq", bus.RREQ, 2'b01);
    chk("b2b2_hold", bus.HOLD, 1);
    chk("b2b2_cmux", bus.CMUXSEL, 0);
    bus.OPCODE = 7'd0;
    tick();
    bus.RDY = 2'b01;
    tick();
    chk("b2b2_cmux_rel", bus.CMUXSEL, 1);
    bus.RDY = 2'b00;
    tick();

    // Reset pulse mid-WAIT
    set_in(LOAD, 3'b010, 2'b00, 1'b0, 2'b00);
    tick();
    bus.OPCODE = 7'd0;
    tick();
    tick();
    chk("mid_hold", bus.HOLD, 1);
    chk("mid_code_pre", bus.ERR_CODE, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_hold", bus.HOLD, 0);
    chk("mid_rst_rreq", bus.RREQ, 0);
    chk("mid_rst_cwe", bus.CWE, 0);
    chk("mid_rst_cmux", bus.CMUXSEL, 0);
    chk("mid_rst_err", bus.ERR, 0);
    chk("mid_rst_code", bus.ERR_CODE, 0);
    chk("mid_rst_signed", bus.SIGNED, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_rreq", bus.RREQ, 0);
    chk("post_rst_hold", bus.HOLD, 0);
    bus.RDY = 2'b01;
    tick();
    chk("post_rst_idle_hold", bus.HOLD, 0);
    chk("post_rst_idle_cmux", bus.CMUXSEL, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
